gfx_clear_multi: RTL and testbench
==================================

Name: gfx_clear_multi

Overview:
- Parametrised clear engine for the fragment-side per-pixel storage planes (mask plus optional further planes, e.g. depth/stencil).
- Clears either the full linear buffer or a linear region, LANES pixels per beat, with a valid/ready handshake toward memory.
- When idle, it forwards single-pixel ROP mask writes with a one-cycle registered delay.
- Sits between the ROP and the fragment-plane write port. It generalises the earlier full-buffer, single-plane, one-pixel-per-cycle clear.

Parameters:
- ADDR_W, 19: pixel address width.
- LINEAR_RES, 307200: pixels in the buffer (640x480).
- LANES, 4: pixels per write beat. Must be a power of two, ≥1.
- PLANES, 2: number of clearable planes. Plane 0 is the fragment mask.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_clear  in  1  clear request (level); held by the requester until busy=1
- clear_base  in  ADDR_W  first pixel; low log2(LANES) bits ignored (aligned down)
- clear_len  in  ADDR_W+1  pixel count; 0 means the full buffer starting at pixel 0
- clear_planes  in  PLANES  planes to clear; sampled at acceptance
- busy  out  1  clear in progress
- done  out  1  one-cycle pulse after the last clear beat is accepted
- rop_mask_addr  in  ADDR_W  pass-through pixel address
- rop_mask_assert  in  1  pass-through write request
- frag_wait  out  1  upstream must hold rop_mask_assert/addr
- frag_write_ready  in  1  memory accepts the current beat
- frag_mask_write  out  1  beat valid
- frag_mask_write_addr  out  ADDR_W  beat base pixel, LANES-aligned
- frag_mask_set  out  1  value to write (1 = pass-through set, 0 = clear)
- frag_lane_en  out  LANES  per-pixel enables within the beat
- frag_plane_en  out  PLANES  planes written by the beat

Behaviour:
- Reset values (next cycle after rst high, any state):
  - state IDLE; busy=0, done=0, frag_mask_write=0
  - frag_mask_set=1, frag_lane_en=0, frag_plane_en=0, frag_mask_write_addr=0
  - any clear in flight is abandoned with no done pulse
- Handshake:
  - A beat transfers when frag_mask_write && frag_write_ready.
  - While frag_mask_write=1 and frag_write_ready=0, all frag_* outputs hold.
  - Output slot is "free" when !frag_mask_write || frag_write_ready.
- IDLE state:
  - frag_wait = start_clear || (frag_mask_write && !frag_write_ready).
  - If the slot is free and start_clear=0, the output register loads the pass-through:
    - frag_mask_write <= rop_mask_assert
    - addr <= rop_mask_addr aligned down to LANES
    - frag_lane_en <= one-hot(rop_mask_addr mod LANES)
    - frag_plane_en <= plane 0 only
    - frag_mask_set <= 1
    - Latency: one cycle.
  - If the slot is free and start_clear=1, the clear is accepted:
    - compute start S and end E; go to CLEAR; busy <= 1
    - first clear beat is valid the next cycle
    - the rop request in the same cycle is not consumed (frag_wait=1)
- Region arithmetic:
  - clear_len=0: S=0, E=LINEAR_RES.
  - Otherwise: S=align(clear_base), E=min(S+clear_len, LINEAR_RES). No wrap-around.
  - Compute E in ADDR_W+2 bits so it cannot overflow.
  - If S ≥ E or clear_planes=0: zero beats; go straight to DONE.
- CLEAR state:
  - frag_wait=1; start_clear is ignored.
  - Beats cover addr = S, S+LANES, …, all with frag_mask_set=0 and frag_plane_en=clear_planes.
  - lane_en bit i = (addr+i < E).
  - The address advances only on transfer.
  - On transfer of the beat with addr+LANES ≥ E, go to DONE and drop frag_mask_write unless a new pass-through load occurs (see DONE).
- DONE state (one cycle):
  - done=1, busy=0, frag_wait = start_clear.
  - Acts as IDLE for pass-through loading; a new start_clear is accepted from the following cycle.
- busy is 1 exactly in CLEAR.

Test Plan:
- Reset, then idle pass-through with ready=1: rop_mask_assert=1, addr=13 -> next cycle write=1, addr=12, lane_en=0010, plane_en=01, set=1.
- Full clear: clear_len=0, clear_planes=11, ready=1 -> 76800 beats, addr 0..307196 step 4, lane_en=1111, set=0, done pulses once, busy low after.
- Region partial tail: base=9, len=10 -> S=8, E=18; beats addr 8,12,16 with lane_en 1111,1111,0011; done after the third transfer.
- Backpressure: ready toggles 1,0,0,1 during a clear -> addr/lane_en hold while ready=0; no beat skipped or duplicated; frag_wait=1 throughout.
- Edge requests:
  - base=307196, len=100 -> one beat, lane_en=1111, clamped
  - clear_planes=0 -> no beats, done the cycle after acceptance
  - start_clear while a pass-through beat is stalled -> clear accepted only after that beat transfers
- rst asserted mid-clear -> outputs at reset values next cycle, no done pulse; a subsequent clear runs normally.

Source files
------------

// File: rtl/gfx_clear_multi.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_clear_multi
//  Description : Multi-plane, multi-lane clear engine for the fragment-side
//                per-pixel storage planes. Clears the full buffer or a linear
//                region LANES pixels per beat over a valid/ready port, and
//                forwards single-pixel ROP mask writes when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module gfx_clear_multi #(
   parameter int ADDR_W     = 19,
   parameter int LINEAR_RES = 307200,
   parameter int LANES      = 4,
   parameter int PLANES     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_clear,
   input  logic [ADDR_W-1:0] clear_base,
   input  logic [ADDR_W:0]   clear_len,
   input  logic [PLANES-1:0] clear_planes,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] rop_mask_addr,
   input  logic              rop_mask_assert,
   output logic              frag_wait,
   input  logic              frag_write_ready,
   output logic              frag_mask_write,
   output logic [ADDR_W-1:0] frag_mask_write_addr,
   output logic              frag_mask_set,
   output logic [LANES-1:0]  frag_lane_en,
   output logic [PLANES-1:0] frag_plane_en
);

   // End addresses carry two extra bits so base + length can never wrap.
   localparam int                END_W      = ADDR_W + 2;
   localparam logic [ADDR_W-1:0] LANE_MASK  = ADDR_W'(LANES - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~LANE_MASK;
   localparam logic [END_W-1:0]  RES_END    = END_W'(LINEAR_RES);
   localparam logic [END_W-1:0]  LANES_E    = END_W'(LANES);
   localparam logic [PLANES-1:0] MASK_PLANE = PLANES'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               write_q, write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               set_q, set_d;
   logic [LANES-1:0]   lane_en_q, lane_en_d;
   logic [PLANES-1:0]  plane_en_q, plane_en_d;
   logic [END_W-1:0]   end_q, end_d;

   logic               slot_free;
   logic [ADDR_W-1:0]  base_aligned;
   logic [END_W-1:0]   region_sum;
   logic [ADDR_W-1:0]  region_start;
   logic [END_W-1:0]   region_end;
   logic               region_empty;
   logic [END_W-1:0]   next_addr_ext;
   logic               last_beat;

   // Lanes of a beat starting at base that fall below the exclusive limit.
   function automatic logic [LANES-1:0] span_lanes(input logic [ADDR_W-1:0] base,
                                                   input logic [END_W-1:0]  lim);
      logic [LANES-1:0] en;
      en = '0;
      for (int i = 0; i < LANES; i++) begin
         en[i] = (({2'b00, base} + END_W'(i)) < lim);
      end
      return en;
   endfunction

   // One-hot lane select for a single pixel address.
   function automatic logic [LANES-1:0] pixel_lane(input logic [ADDR_W-1:0] a);
      logic [LANES-1:0]  en;
      logic [ADDR_W-1:0] idx;
      idx = a & LANE_MASK;
      en  = '0;
      for (int i = 0; i < LANES; i++) begin
         en[i] = (idx == ADDR_W'(i));
      end
      return en;
   endfunction

   // Region bounds for a clear request; length zero selects the whole buffer.
   always_comb begin
      base_aligned = clear_base & ALIGN_MASK;
      region_sum   = {2'b00, base_aligned} + {1'b0, clear_len};
      region_start = '0;
      region_end   = RES_END;
      if (clear_len != '0) begin
         region_start = base_aligned;
         region_end   = (region_sum > RES_END) ? RES_END : region_sum;
      end
      region_empty = ({2'b00, region_start} >= region_end) || (clear_planes == '0);
   end

   // Next-state and output-register loading for pass-through and clear beats.
   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      addr_d     = addr_q;
      set_d      = set_q;
      lane_en_d  = lane_en_q;
      plane_en_d = plane_en_q;
      end_d      = end_q;

      slot_free     = !write_q || frag_write_ready;
      next_addr_ext = {2'b00, addr_q} + LANES_E;
      last_beat     = (next_addr_ext >= end_q);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
            if (slot_free) begin
               if (!start_clear) begin
                  write_d    = rop_mask_assert;
                  addr_d     = rop_mask_addr & ALIGN_MASK;
                  lane_en_d  = pixel_lane(rop_mask_addr);
                  plane_en_d = MASK_PLANE;
                  set_d      = 1'b1;
               end else if (state_q == ST_IDLE) begin
                  end_d = region_end;
                  if (region_empty) begin
                     state_d = ST_DONE;
                     write_d = 1'b0;
                  end else begin
                     state_d    = ST_CLEAR;
                     write_d    = 1'b1;
                     addr_d     = region_start;
                     lane_en_d  = span_lanes(region_start, region_end);
                     plane_en_d = clear_planes;
                     set_d      = 1'b0;
                  end
               end else begin
                  // A request arriving during DONE waits for IDLE; nothing is loaded.
                  write_d = 1'b0;
               end
            end
         end
         ST_CLEAR: begin
            if (write_q && frag_write_ready) begin
               if (last_beat) begin
                  state_d = ST_DONE;
                  write_d = 1'b0;
               end else begin
                  addr_d    = next_addr_ext[ADDR_W-1:0];
                  lane_en_d = span_lanes(next_addr_ext[ADDR_W-1:0], end_q);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            write_d = 1'b0;
         end
      endcase
   end

   // Upstream stall: any clear activity or a stalled beat holds the ROP.
   always_comb begin
      case (state_q)
         ST_IDLE:  frag_wait = start_clear || (write_q && !frag_write_ready);
         ST_CLEAR: frag_wait = 1'b1;
         ST_DONE:  frag_wait = start_clear;
         default:  frag_wait = 1'b1;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         write_q    <= 1'b0;
         addr_q     <= '0;
         set_q      <= 1'b1;
         lane_en_q  <= '0;
         plane_en_q <= '0;
         end_q      <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         set_q      <= set_d;
         lane_en_q  <= lane_en_d;
         plane_en_q <= plane_en_d;
         end_q      <= end_d;
      end
   end

   assign busy                 = (state_q == ST_CLEAR);
   assign done                 = (state_q == ST_DONE);
   assign frag_mask_write      = write_q;
   assign frag_mask_write_addr = addr_q;
   assign frag_mask_set        = set_q;
   assign frag_lane_en         = lane_en_q;
   assign frag_plane_en        = plane_en_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_clear_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gfx_clear_multi
//  Description : Directed self-checking bench for gfx_clear_multi.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_clear_multi;

   localparam int ADDR_W     = 19;
   localparam int LINEAR_RES = 307200;
   localparam int LANES      = 4;
   localparam int PLANES     = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_clear;
   logic [ADDR_W-1:0] clear_base;
   logic [ADDR_W:0]   clear_len;
   logic [PLANES-1:0] clear_planes;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rop_mask_addr;
   logic              rop_mask_assert;
   logic              frag_wait;
   logic              frag_write_ready;
   logic              frag_mask_write;
   logic [ADDR_W-1:0] frag_mask_write_addr;
   logic              frag_mask_set;
   logic [LANES-1:0]  frag_lane_en;
   logic [PLANES-1:0] frag_plane_en;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gfx_clear_multi #(
      .ADDR_W     (ADDR_W),
      .LINEAR_RES (LINEAR_RES),
      .LANES      (LANES),
      .PLANES     (PLANES)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start_clear          (start_clear),
      .clear_base           (clear_base),
      .clear_len            (clear_len),
      .clear_planes         (clear_planes),
      .busy                 (busy),
      .done                 (done),
      .rop_mask_addr        (rop_mask_addr),
      .rop_mask_assert      (rop_mask_assert),
      .frag_wait            (frag_wait),
      .frag_write_ready     (frag_write_ready),
      .frag_mask_write      (frag_mask_write),
      .frag_mask_write_addr (frag_mask_write_addr),
      .frag_mask_set        (frag_mask_set),
      .frag_lane_en         (frag_lane_en),
      .frag_plane_en        (frag_plane_en)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                      input logic [PLANES-1:0] p);
      clear_base   = b;
      clear_len    = l;
      clear_planes = p;
      start_clear  = 1'b1;
      tick();
      start_clear  = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [ADDR_W-1:0] a,
                       input logic [LANES-1:0] ln, input logic [PLANES-1:0] p);
      chk({tag, "_write"}, frag_mask_write, 1'b1);
      chk({tag, "_addr"}, frag_mask_write_addr, a);
      chk({tag, "_lane"}, frag_lane_en, ln);
      chk({tag, "_plane"}, frag_plane_en, p);
      chk({tag, "_set"}, frag_mask_set, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_wait"}, frag_wait, 1'b1);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_write"}, frag_mask_write, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_set"}, frag_mask_set, 1'b1);
      chk({tag, "_lane"}, frag_lane_en, 4'h0);
      chk({tag, "_plane"}, frag_plane_en, 2'b00);
      chk({tag, "_addr"}, frag_mask_write_addr, 19'd0);
   endtask

   initial begin
      int beats;
      int bad;
      int dones;
      int exp_addr;

      rst              = 1'b1;
      start_clear      = 1'b0;
      clear_base       = '0;
      clear_len        = '0;
      clear_planes     = '0;
      rop_mask_addr    = '0;
      rop_mask_assert  = 1'b0;
      frag_write_ready = 1'b1;
      tick();
      tick();
      reset_vals("reset");
      rst = 1'b0;
      tick();

      // Idle pass-through, one-cycle latency
      rop_mask_assert = 1'b1;
      rop_mask_addr   = 19'd13;
      tick();
      chk("pt_write", frag_mask_write, 1'b1);
      chk("pt_addr", frag_mask_write_addr, 19'd12);
      chk("pt_lane", frag_lane_en, 4'b0010);
      chk("pt_plane", frag_plane_en, 2'b01);
      chk("pt_set", frag_mask_set, 1'b1);
      chk("pt_wait", frag_wait, 1'b0);
      rop_mask_addr = 19'd7;
      tick();
      chk("pt2_addr", frag_mask_write_addr, 19'd4);
      chk("pt2_lane", frag_lane_en, 4'b1000);
      rop_mask_assert = 1'b0;
      tick();
      chk("pt_idle_write", frag_mask_write, 1'b0);

      // Full-buffer clear
      req('0, '0, 2'b11);
      beats = 0; bad = 0; dones = 0; exp_addr = 0;
      for (int c = 0; c < 80000 && dones == 0; c++) begin
         if (frag_mask_write) begin
            if (frag_mask_write_addr !== exp_addr[ADDR_W-1:0] || frag_lane_en !== 4'hF ||
                frag_mask_set !== 1'b0 || frag_plane_en !== 2'b11 || frag_wait !== 1'b1 ||
                busy !== 1'b1)
               bad++;
            exp_addr += 4;
            beats++;
         end
         tick();
         if (done) dones++;
      end
      chk("full_beats", beats, 32'd76800);
      chk("full_bad_beats", bad, 32'd0);
      chk("full_done_seen", dones, 32'd1);
      chk("full_busy_at_done", busy, 1'b0);
      chk("full_write_at_done", frag_mask_write, 1'b0);
      tick();
      chk("full_done_once", done, 1'b0);
      chk("full_busy_after", busy, 1'b0);

      // Region with partial tail: S=8, E=18
      req(19'd9, 20'd10, 2'b01);
      beat("reg0", 19'd8, 4'hF, 2'b01);
      tick();
      beat("reg1", 19'd12, 4'hF, 2'b01);
      tick();
      beat("reg2", 19'd16, 4'b0011, 2'b01);
      chk("reg2_done_early", done, 1'b0);
      tick();
      chk("reg_done", done, 1'b1);
      chk("reg_write_off", frag_mask_write, 1'b0);
      chk("reg_busy_off", busy, 1'b0);
      tick();
      chk("reg_done_pulse", done, 1'b0);

      // Backpressure: ready 1,0,0,1 across a 4-beat clear
      req(19'd0, 20'd16, 2'b10);
      beat("bp0", 19'd0, 4'hF, 2'b10);
      tick();
      beat("bp1", 19'd4, 4'hF, 2'b10);
      frag_write_ready = 1'b0;
      tick();
      beat("bp_hold1", 19'd4, 4'hF, 2'b10);
      tick();
      beat("bp_hold2", 19'd4, 4'hF, 2'b10);
      frag_write_ready = 1'b1;
      tick();
      beat("bp2", 19'd8, 4'hF, 2'b10);
      tick();
      beat("bp3", 19'd12, 4'hF, 2'b10);
      tick();
      chk("bp_done", done, 1'b1);
      tick();

      // Clamped region at the end of the buffer
      req(19'd307196, 20'd100, 2'b11);
      beat("clamp", 19'd307196, 4'hF, 2'b11);
      tick();
      chk("clamp_done", done, 1'b1);
      chk("clamp_write_off", frag_mask_write, 1'b0);
      tick();

      // No planes selected: zero beats, done next cycle
      req(19'd0, 20'd8, 2'b00);
      chk("noplane_done", done, 1'b1);
      chk("noplane_write", frag_mask_write, 1'b0);
      chk("noplane_busy", busy, 1'b0);
      tick();

      // Clear request while a pass-through beat is stalled
      frag_write_ready = 1'b0;
      rop_mask_assert  = 1'b1;
      rop_mask_addr    = 19'd5;
      tick();
      chk("stall_pt_addr", frag_mask_write_addr, 19'd4);
      chk("stall_pt_lane", frag_lane_en, 4'b0010);
      clear_base   = 19'd0;
      clear_len    = 20'd4;
      clear_planes = 2'b01;
      start_clear  = 1'b1;
      #1;
      chk("stall_wait", frag_wait, 1'b1);
      tick();
      chk("stall_not_accepted", busy, 1'b0);
      chk("stall_pt_held", frag_mask_write_addr, 19'd4);
      chk("stall_pt_set", frag_mask_set, 1'b1);
      frag_write_ready = 1'b1;
      tick();
      start_clear     = 1'b0;
      rop_mask_assert = 1'b0;
      beat("stall_clr", 19'd0, 4'hF, 2'b01);
      tick();
      chk("stall_done", done, 1'b1);
      tick();

      // Reset in the middle of a full clear
      req('0, '0, 2'b01);
      tick();
      tick();
      beat("mid", 19'd8, 4'hF, 2'b01);
      rst = 1'b1;
      tick();
      reset_vals("midrst");
      rst = 1'b0;
      tick();
      chk("midrst_no_done", done, 1'b0);
      chk("midrst_idle_busy", busy, 1'b0);
      req(19'd4, 20'd4, 2'b11);
      beat("post", 19'd4, 4'hF, 2'b11);
      tick();
      chk("post_done", done, 1'b1);
      tick();
      chk("post_idle", done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
